// File: rtl/iq_demod_accum.sv
`timescale 1ns/1ps
`default_nettype none
// iq_demod_accum: windowed I/Q correlator driving a cos/sin lookup phase index.
// Rev 1.0 - initial release.
module iq_demod_accum #(
  parameter int SAMPLE_W   = 12,
  parameter int TRIG_W     = 48,
  parameter int ACC_W      = 48,
  parameter int PROD_SHIFT = 30,
  parameter int ANGLE_STEP = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [15:0]                win_len,
  input  logic [8:0]                 phase_init,
  input  logic                       sample_valid,
  input  logic signed [SAMPLE_W-1:0] sample,
  output logic [8:0]                 angle,
  input  logic signed [TRIG_W-1:0]   cos_in,
  input  logic signed [TRIG_W-1:0]   sin_in,
  output logic                       busy,
  output logic signed [ACC_W-1:0]    i_out,
  output logic signed [ACC_W-1:0]    q_out,
  output logic                       out_valid
);

  localparam int         PROD_W       = SAMPLE_W + TRIG_W;
  localparam logic [9:0] c_ANGLE_MOD  = 10'd400;
  localparam logic [9:0] c_ANGLE_STEP = 10'(ANGLE_STEP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [15:0]                r_win_len;
  logic [15:0]                r_cnt;
  logic signed [SAMPLE_W-1:0] r_s1;
  logic                       r_v1;
  logic                       r_last1;
  logic signed [PROD_W-1:0]   r_prod_c;
  logic signed [PROD_W-1:0]   r_prod_s;
  logic                       r_v2;
  logic                       r_last2;
  logic signed [ACC_W-1:0]    r_acc_i;
  logic signed [ACC_W-1:0]    r_acc_q;

  logic                       w_start_ok;
  logic                       w_accept;
  logic                       w_last_accept;
  logic                       w_final;
  logic [9:0]                 w_angle_sum;
  logic [8:0]                 w_angle_next;
  logic [8:0]                 w_phase_start;
  logic signed [ACC_W-1:0]    w_term_c;
  logic signed [ACC_W-1:0]    w_term_s;
  logic signed [ACC_W-1:0]    w_sum_i;
  logic signed [ACC_W-1:0]    w_sum_q;

  assign w_start_ok    = (r_state == S_IDLE) && start && (win_len != 16'd0);
  assign w_accept      = (r_state == S_RUN) && sample_valid;
  assign w_last_accept = w_accept && ((r_cnt + 16'd1) == r_win_len);
  assign w_final       = r_v2 && r_last2;

  // Phase index wraps modulo 400; the pre-edge value pairs with the accepted sample.
  assign w_angle_sum   = {1'b0, angle} + c_ANGLE_STEP;
  assign w_angle_next  = (w_angle_sum >= c_ANGLE_MOD) ? 9'(w_angle_sum - c_ANGLE_MOD)
                                                      : 9'(w_angle_sum);
  assign w_phase_start = (phase_init >= 9'd400) ? 9'd0 : phase_init;

  assign w_term_c = ACC_W'(r_prod_c >>> PROD_SHIFT);
  assign w_term_s = ACC_W'(r_prod_s >>> PROD_SHIFT);
  assign w_sum_i  = r_acc_i + w_term_c;
  assign w_sum_q  = r_acc_q + w_term_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok)    w_state_nxt = S_RUN;
      S_RUN:   if (w_last_accept) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_final)       w_state_nxt = S_IDLE;
      default:                    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win_len <= '0;
      r_cnt     <= '0;
      r_s1      <= '0;
      r_v1      <= 1'b0;
      r_last1   <= 1'b0;
      r_prod_c  <= '0;
      r_prod_s  <= '0;
      r_v2      <= 1'b0;
      r_last2   <= 1'b0;
      r_acc_i   <= '0;
      r_acc_q   <= '0;
      angle     <= '0;
      busy      <= 1'b0;
      i_out     <= '0;
      q_out     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;

      // Stage 1: capture sample and step the phase index.
      r_v1    <= w_accept;
      r_last1 <= w_last_accept;
      if (w_accept) begin
        r_s1  <= sample;
        r_cnt <= r_cnt + 16'd1;
        angle <= w_angle_next;
      end

      // Stage 2: full-precision products against the registered lookup words.
      r_v2    <= r_v1;
      r_last2 <= r_last1;
      if (r_v1) begin
        r_prod_c <= PROD_W'(r_s1) * PROD_W'(cos_in);
        r_prod_s <= PROD_W'(r_s1) * PROD_W'(sin_in);
      end

      // Stage 3: accumulate; the final term lands directly in the outputs.
      if (r_v2) begin
        if (r_last2) begin
          i_out     <= w_sum_i;
          q_out     <= w_sum_q;
          out_valid <= 1'b1;
          busy      <= 1'b0;
        end else begin
          r_acc_i <= w_sum_i;
          r_acc_q <= w_sum_q;
        end
      end

      if (w_start_ok) begin
        r_win_len <= win_len;
        angle     <= w_phase_start;
        r_acc_i   <= '0;
        r_acc_q   <= '0;
        r_cnt     <= '0;
        busy      <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
